// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, error clear and received-byte outputs of uart_rx.
//   i_rxSerial   raw serial line, idle high, asynchronous to the clock
//   i_errorClear level clear for the sticky error flag
//   o_rxData     last good byte
//   o_rxValid    1-cycle pulse, o_rxData just updated
//   o_rxBusy     receiver not idle
//   o_frameError 1-cycle pulse, stop bit sampled low
//   o_rxError    sticky framing-error flag
// slave modport is the receiver side; master is the side that drives the line.
interface uart_rx_if;
    logic       i_rxSerial;
    logic       i_errorClear;
    logic [7:0] o_rxData;
    logic       o_rxValid;
    logic       o_rxBusy;
    logic       o_frameError;
    logic       o_rxError;

    modport slave (
        input  i_rxSerial,
        input  i_errorClear,
        output o_rxData,
        output o_rxValid,
        output o_rxBusy,
        output o_frameError,
        output o_rxError
    );

    modport master (
        output i_rxSerial,
        output i_errorClear,
        input  o_rxData,
        input  o_rxValid,
        input  o_rxBusy,
        input  o_frameError,
        input  o_rxError
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      uart_rx_if.slave: serial in, error clear, byte/valid/busy/error out
// A held-low line after a bad stop bit parks in BREAK so it reports one
// error instead of a stream of bogus frames.
module uart_rx #(
    parameter int unsigned CLOCKS_PER_BIT = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    uart_rx_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int unsigned HALF  = (CLOCKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_err;
    logic             r_busy;

    logic             w_rx_s;
    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [2:0]       w_idx_nx;
    logic [7:0]       w_shift_nx;
    logic [7:0]       w_data_nx;
    logic             w_valid_nx;
    logic             w_ferr_nx;
    logic             w_err_nx;
    logic             w_busy_nx;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser, reset to the idle (high) line level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.i_rxSerial;
            r_sync2 <= r_sync1;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_ferr  <= w_ferr_nx;
            r_err   <= w_err_nx;
            r_busy  <= w_busy_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_data_nx  = r_data;
        w_valid_nx = 1'b0;
        w_ferr_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nx = S_START;
                    w_cnt_nx   = '0;
                end
            end

            // Recheck the line at mid start bit; a high here was a glitch
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nx = '0;
                    if (!w_rx_s) begin
                        w_state_nx = S_DATA;
                        w_idx_nx   = '0;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end

            // Counting from mid start bit, each terminal count lands mid data bit
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx          = '0;
                    w_shift_nx[r_idx] = w_rx_s;
                    if (r_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx = '0;
                    if (w_rx_s) begin
                        w_data_nx  = r_shift;
                        w_valid_nx = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = S_BREAK;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end

            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase

        // A new framing error takes priority over a clear in the same cycle
        if (w_ferr_nx) begin
            w_err_nx = 1'b1;
        end else if (bus.i_errorClear) begin
            w_err_nx = 1'b0;
        end else begin
            w_err_nx = r_err;
        end

        // Registered from the next state so busy tracks the current state exactly
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    assign bus.o_rxData     = r_data;
    assign bus.o_rxValid    = r_valid;
    assign bus.o_rxBusy     = r_busy;
    assign bus.o_frameError = r_ferr;
    assign bus.o_rxError    = r_err;

endmodule
